// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with byte-masked writes, optional
// hardwired-zero entry 0 and a one-entry-per-cycle soft-clear sweep.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  input  logic                     clr,
  output logic                     busy
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_idx, w_idx_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   w_wr_merged;
  logic                w_wr_en;
  logic                w_zero_hit;

  assign busy       = (r_state == S_CLEAR);
  assign wr_ready   = ~busy;
  assign w_zero_hit = (ZERO_REG != 0) && (wr_addr == '0);
  assign w_wr_en    = we && wr_ready && (|wr_be) && !w_zero_hit;

  always_comb begin
    w_wr_merged = r_mem[wr_addr];
    for (int b = 0; b < NB; b++)
      if (wr_be[b]) w_wr_merged[8*b +: 8] = wr_data[8*b +: 8];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_clr_idx;
    case (r_state)
      S_IDLE: if (clr) begin
        w_state_nxt = S_CLEAR;
        w_idx_nxt   = '0;
      end
      S_CLEAR: begin
        w_idx_nxt = r_clr_idx + ADDR_W'(1);
        if (&r_clr_idx) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sweep takes priority over the write port; the write is simply not accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_clr_idx <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_idx_nxt;
      if (busy)         r_mem[r_clr_idx] <= '0;
      else if (w_wr_en) r_mem[wr_addr]   <= w_wr_merged;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    logic [DATA_W-1:0] w_q;
    assign w_a = rd_addr[k*ADDR_W +: ADDR_W];
    always_comb begin
      w_q = r_mem[w_a];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_en && (w_a == wr_addr)) w_q = w_wr_merged;
`endif
      if ((ZERO_REG != 0) && (w_a == '0)) w_q = '0;
    end
    assign rd_data[k*DATA_W +: DATA_W] = w_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: two instances (ZERO_REG=1 and 0) share stimulus
// and are checked every cycle against an array model plus literal expectations.
module tb_regfile_mp;
  logic        clk = 0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic        we;
  logic [4:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        clr;
  logic [63:0] rd_data1, rd_data0;
  logic        wr_ready1, wr_ready0, busy1, busy0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1), .we(we),
    .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_ready(wr_ready1),
    .clr(clr), .busy(busy1));

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0), .we(we),
    .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_ready(wr_ready0),
    .clr(clr), .busy(busy0));

  // Model: m1 is the ZERO_REG=1 array, m0 the ordinary one; sweep tracked as
  // a flag plus a plain integer position.
  logic [31:0] m1 [32];
  logic [31:0] m0 [32];
  bit          mbusy = 0;
  int          mpos  = 0;

  function automatic logic [31:0] merge(input logic [31:0] old);
    logic [31:0] v = old;
    for (int b = 0; b < 4; b++) if (wr_be[b]) v[8*b +: 8] = wr_data[8*b +: 8];
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m1[i] = 0; m0[i] = 0; end
      mbusy = 0; mpos = 0;
    end else if (mbusy) begin
      m1[mpos] = 0; m0[mpos] = 0;
      mpos = mpos + 1;
      if (mpos == 32) begin mbusy = 0; mpos = 0; end
    end else begin
      if (we && wr_be != 0) begin
        if (wr_addr != 0) m1[wr_addr] = merge(m1[wr_addr]);
        m0[wr_addr] = merge(m0[wr_addr]);
      end
      if (clr) begin mbusy = 1; mpos = 0; end
    end
  end

  function automatic logic [31:0] exp_rd(input bit z, input int a);
    logic [31:0] v = z ? m1[a] : m0[a];
`ifdef REGFILE_BYPASS_EN
    if (we && !mbusy && wr_be != 0 && a == int'(wr_addr) && !(z && a == 0)) v = merge(v);
`endif
    if (z && a == 0) v = 0;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    cmp("busy", 32'(busy1), 32'(mbusy));
    cmp("wr_ready", 32'(wr_ready1), 32'(!mbusy));
    cmp("busy_z0", 32'(busy0), 32'(mbusy));
    for (int k = 0; k < 2; k++) begin
      cmp($sformatf("rd%0d", k), rd_data1[32*k +: 32], exp_rd(1, int'(rd_addr[5*k +: 5])));
      cmp($sformatf("rd%0d_z0", k), rd_data0[32*k +: 32], exp_rd(0, int'(rd_addr[5*k +: 5])));
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic settle(); @(negedge clk); endtask
  task automatic set_rd(input int p0, input int p1);
    rd_addr = {5'(p1), 5'(p0)};
  endtask
  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    we = 1; wr_addr = 5'(a); wr_data = d; wr_be = be;
    tick();
    we = 0;
  endtask
  task automatic all_zero(input string nm);
    for (int a = 0; a < 32; a += 2) begin
      set_rd(a, a + 1);
      settle();
      cmp(nm, rd_data1[31:0] | rd_data1[63:32] | rd_data0[31:0] | rd_data0[63:32], 32'h0);
      tick();
    end
  endtask

  initial begin
    int n;
    rst = 1; we = 0; wr_addr = 0; wr_be = 0; wr_data = 0; clr = 0; rd_addr = 0;
    tick();
    chk_en = 1;
    tick();
    rst = 0;

    // reset state
    set_rd(5, 6);
    settle();
    cmp("rst_busy", 32'(busy1), 32'h0);
    cmp("rst_ready", 32'(wr_ready1), 32'h1);
    cmp("rst_rd", rd_data1[31:0] | rd_data1[63:32], 32'h0);
    tick();

    // basic write, byte mask
    wr(5, 32'hDEADBEEF, 4'hF);
    settle();
    cmp("wr_p0", rd_data1[31:0], 32'hDEADBEEF);
    cmp("wr_p1", rd_data1[63:32], 32'h0);
    tick();
    wr(5, 32'h11223344, 4'b0101);
    settle();
    cmp("byte_mask", rd_data1[31:0], 32'hDE22BE44);
    tick();

    // zero register vs ordinary entry 0
    set_rd(0, 5);
    wr(0, 32'hFFFFFFFF, 4'hF);
    settle();
    cmp("zero_reg", rd_data1[31:0], 32'h0);
    cmp("no_zero_reg", rd_data0[31:0], 32'hFFFFFFFF);
    tick();

    // same-cycle read of the written address
    set_rd(9, 5);
    we = 1; wr_addr = 9; wr_data = 32'h12345678; wr_be = 4'hF;
    settle();
`ifdef REGFILE_BYPASS_EN
    cmp("bypass_same", rd_data1[31:0], 32'h12345678);
`else
    cmp("bypass_same", rd_data1[31:0], 32'h0);
`endif
    tick();
    we = 0;
    settle();
    cmp("bypass_next", rd_data1[31:0], 32'h12345678);
    tick();

    // soft clear sweep
    for (int i = 1; i < 32; i++) wr(i, 32'(i), 4'hF);
    clr = 1;
    tick();
    clr = 0;
    n = 0;
    while (n < 40) begin
      we = (n == 0); wr_addr = 3; wr_data = 32'hAA; wr_be = 4'hF;
      clr = (n == 5);
      if (n == 3) set_rd(2, 10); else set_rd(3, 3);
      settle();
      if (!busy1) break;
      if (n == 3) begin
        cmp("sweep_e2", rd_data1[31:0], 32'h0);
        cmp("sweep_e10", rd_data1[63:32], 32'd10);
      end
      n++;
      tick();
    end
    we = 0; clr = 0;
    cmp("busy_len", 32'(n), 32'd32);
    cmp("ready_after", 32'(wr_ready1), 32'h1);
    tick();
    all_zero("swept_zero");

    // reset mid-sweep
    for (int i = 20; i < 32; i++) wr(i, 32'h100 + 32'(i), 4'hF);
    clr = 1;
    tick();
    clr = 0;
    n = 0;
    while (n < 9 && busy1) begin n++; tick(); end
    rst = 1;
    tick();
    rst = 0;
    settle();
    cmp("mid_rst_busy", 32'(busy1), 32'h0);
    cmp("mid_rst_ready", 32'(wr_ready1), 32'h1);
    tick();
    all_zero("mid_rst_zero");
    set_rd(7, 0);
    wr(7, 32'h77, 4'hF);
    settle();
    cmp("post_rst_wr", rd_data1[31:0], 32'h77);
    tick();

    // rst and clr together: rst wins
    rst = 1; clr = 1;
    tick();
    rst = 0; clr = 0;
    settle();
    cmp("rst_clr_busy", 32'(busy1), 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
